// File: rtl/dmac_burst_pkg.sv
// Shared types and constants for the DMAC burst splitter front-end.
package dmac_burst_pkg;

   // AXI bursts must never cross this boundary, whatever the configured burst size.
   localparam int BOUNDARY_4K = 4096;

   localparam int PKG_ADDR_W = 32;
   localparam int PKG_LEN_W  = 24;
   localparam int PKG_Y_W    = 16;

   typedef struct packed {
      logic [PKG_ADDR_W-1:0] addr;
      logic [PKG_LEN_W-1:0]  x_length;
      logic [PKG_Y_W-1:0]    y_length;
      logic [PKG_LEN_W-1:0]  stride;
   } burst_req_t;

   typedef struct packed {
      logic [PKG_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic                  eol;
      logic                  last;
   } burst_desc_t;

   function automatic int beat_shift(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/dmac_burst_calc.sv
// Combinational sizing of one burst: bytes up to the next burst-aligned boundary
// or the end of the row, whichever is nearer, plus the address following it.
module dmac_burst_calc
   import dmac_burst_pkg::*;
#(
   parameter int ADDR_WIDTH          = 32,
   parameter int REM_WIDTH           = 25,
   parameter int Y_LENGTH_WIDTH      = 16,
   parameter int BEAT_SHIFT          = 3,
   parameter int MAX_BYTES_PER_BURST = 128
) (
   input  logic [ADDR_WIDTH-1:0]     i_cur_addr,
   input  logic [REM_WIDTH-1:0]      i_row_rem,
   input  logic [Y_LENGTH_WIDTH-1:0] i_rows_rem,
   output logic [REM_WIDTH-1:0]      o_bytes,
   output logic [7:0]                o_len,
   output logic                      o_eol,
   output logic                      o_last,
   output logic [ADDR_WIDTH-1:0]     o_next_addr
);

   localparam int EFF_MAX = (MAX_BYTES_PER_BURST > BOUNDARY_4K) ? BOUNDARY_4K
                                                                 : MAX_BYTES_PER_BURST;
   localparam int MBW = $clog2(EFF_MAX);

   logic [MBW:0]           w_to_bound;
   logic [REM_WIDTH-1:0]   w_to_bound_ext;

   always_comb begin
      w_to_bound     = (MBW+1)'(EFF_MAX) - (MBW+1)'(i_cur_addr[MBW-1:0]);
      w_to_bound_ext = REM_WIDTH'(w_to_bound);
      o_eol          = (i_row_rem <= w_to_bound_ext);
      o_bytes        = o_eol ? i_row_rem : w_to_bound_ext;
      o_last         = o_eol && (i_rows_rem == '0);
      o_len          = 8'((o_bytes >> BEAT_SHIFT) - REM_WIDTH'(1));
      o_next_addr    = i_cur_addr + ADDR_WIDTH'(o_bytes);
   end

endmodule

// File: rtl/dmac_burst_splitter.sv
// DMAC request front-end: turns one 1D/2D transfer descriptor into a stream of
// boundary-safe burst descriptors at up to one burst per cycle.
module dmac_burst_splitter
   import dmac_burst_pkg::*;
#(
   parameter int ADDR_WIDTH          = 32,
   parameter int LENGTH_WIDTH        = 24,
   parameter int Y_LENGTH_WIDTH      = 16,
   parameter int DMA_DATA_WIDTH      = 64,
   parameter int MAX_BYTES_PER_BURST = 128,
   parameter int DMA_2D_TRANSFER     = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [LENGTH_WIDTH-1:0]   req_x_length,
   input  logic [Y_LENGTH_WIDTH-1:0] req_y_length,
   input  logic [LENGTH_WIDTH-1:0]   req_stride,
   input  logic                      req_abort,
   output logic                      burst_valid,
   input  logic                      burst_ready,
   output logic [ADDR_WIDTH-1:0]     burst_addr,
   output logic [7:0]                burst_len,
   output logic                      burst_eol,
   output logic                      burst_last,
   output logic                      busy,
   output logic                      aborted
);

   localparam int BEAT_SHIFT = beat_shift(DMA_DATA_WIDTH);
   localparam int BEAT_BYTES = DMA_DATA_WIDTH / 8;
   localparam int REM_WIDTH  = LENGTH_WIDTH + 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SPLIT = 1'b1;

   localparam logic [ADDR_WIDTH-1:0]   ADDR_MASK = ~ADDR_WIDTH'(BEAT_BYTES - 1);
   localparam logic [LENGTH_WIDTH-1:0] LEN_LOW   = LENGTH_WIDTH'(BEAT_BYTES - 1);

   logic [0:0]                r_state;
   logic                      r_abort;
   logic [ADDR_WIDTH-1:0]     r_row_start;
   logic [ADDR_WIDTH-1:0]     r_cur_addr;
   logic [REM_WIDTH-1:0]      r_row_rem;
   logic [Y_LENGTH_WIDTH-1:0] r_rows_rem;
   logic [REM_WIDTH-1:0]      r_xlen1;
   logic [LENGTH_WIDTH-1:0]   r_stride;
   logic                      r_burst_valid;
   logic [ADDR_WIDTH-1:0]     r_burst_addr;
   logic [7:0]                r_burst_len;
   logic                      r_burst_eol;
   logic                      r_burst_last;
   logic                      r_aborted;

   logic                      w_idle;
   logic                      w_accept;
   logic                      w_hs;
   logic                      w_load;
   logic                      w_finish;
   logic [ADDR_WIDTH-1:0]     w_req_addr;
   logic [REM_WIDTH-1:0]      w_req_xlen1;
   logic [Y_LENGTH_WIDTH-1:0] w_req_rows;
   logic [ADDR_WIDTH-1:0]     w_base_row;
   logic [ADDR_WIDTH-1:0]     w_calc_addr;
   logic [REM_WIDTH-1:0]      w_calc_rem;
   logic [Y_LENGTH_WIDTH-1:0] w_calc_rows;
   logic [REM_WIDTH-1:0]      w_xlen1;
   logic [LENGTH_WIDTH-1:0]   w_stride;
   logic [ADDR_WIDTH-1:0]     w_next_row;
   logic [REM_WIDTH-1:0]      w_bytes;
   logic [7:0]                w_len;
   logic                      w_eol;
   logic                      w_last;
   logic [ADDR_WIDTH-1:0]     w_next_addr;

   // In IDLE the calculator looks straight at the incoming descriptor, so the
   // first burst is registered on the accepting edge; otherwise it sizes the
   // burst that follows the one currently presented.
   always_comb begin
      w_idle      = (r_state == ST_IDLE);
      w_req_addr  = req_addr & ADDR_MASK;
      w_req_xlen1 = {1'b0, req_x_length | LEN_LOW} + REM_WIDTH'(1);
      w_req_rows  = (DMA_2D_TRANSFER != 0) ? req_y_length : '0;
      w_base_row  = w_idle ? w_req_addr  : r_row_start;
      w_calc_addr = w_idle ? w_req_addr  : r_cur_addr;
      w_calc_rem  = w_idle ? w_req_xlen1 : r_row_rem;
      w_calc_rows = w_idle ? w_req_rows  : r_rows_rem;
      w_xlen1     = w_idle ? w_req_xlen1 : r_xlen1;
      w_stride    = w_idle ? req_stride  : r_stride;
      w_next_row  = (w_base_row + ADDR_WIDTH'(w_stride)) & ADDR_MASK;
      w_accept    = w_idle && req_valid;
      w_hs        = r_burst_valid && burst_ready;
      w_finish    = !w_idle && w_hs && (r_burst_last || r_abort || req_abort);
      w_load      = w_accept || (!w_idle && w_hs && !w_finish);
   end

   dmac_burst_calc #(
      .ADDR_WIDTH          (ADDR_WIDTH),
      .REM_WIDTH           (REM_WIDTH),
      .Y_LENGTH_WIDTH      (Y_LENGTH_WIDTH),
      .BEAT_SHIFT          (BEAT_SHIFT),
      .MAX_BYTES_PER_BURST (MAX_BYTES_PER_BURST)
   ) u_calc (
      .i_cur_addr  (w_calc_addr),
      .i_row_rem   (w_calc_rem),
      .i_rows_rem  (w_calc_rows),
      .o_bytes     (w_bytes),
      .o_len       (w_len),
      .o_eol       (w_eol),
      .o_last      (w_last),
      .o_next_addr (w_next_addr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_abort       <= 1'b0;
         r_row_start   <= '0;
         r_cur_addr    <= '0;
         r_row_rem     <= '0;
         r_rows_rem    <= '0;
         r_xlen1       <= '0;
         r_stride      <= '0;
         r_burst_valid <= 1'b0;
         r_burst_addr  <= '0;
         r_burst_len   <= '0;
         r_burst_eol   <= 1'b0;
         r_burst_last  <= 1'b0;
         r_aborted     <= 1'b0;
      end else begin
         r_aborted <= 1'b0;
         if (w_load) begin
            r_burst_valid <= 1'b1;
            r_burst_addr  <= w_calc_addr;
            r_burst_len   <= w_len;
            r_burst_eol   <= w_eol;
            r_burst_last  <= w_last;
            if (w_eol) begin
               r_row_start <= w_next_row;
               r_cur_addr  <= w_next_row;
               r_row_rem   <= w_xlen1;
               r_rows_rem  <= w_calc_rows - Y_LENGTH_WIDTH'(1);
            end else begin
               r_row_start <= w_base_row;
               r_cur_addr  <= w_next_addr;
               r_row_rem   <= w_calc_rem - w_bytes;
               r_rows_rem  <= w_calc_rows;
            end
         end
         if (w_accept) begin
            r_state  <= ST_SPLIT;
            r_abort  <= 1'b0;
            r_xlen1  <= w_req_xlen1;
            r_stride <= req_stride;
         end else if (!w_idle) begin
            if (req_abort) begin
               r_abort <= 1'b1;
            end
            // A natural end wins over a pending abort: no pulse in that case.
            if (w_finish) begin
               r_burst_valid <= 1'b0;
               r_state       <= ST_IDLE;
               r_abort       <= 1'b0;
               r_aborted     <= !r_burst_last;
            end
         end
      end
   end

   assign req_ready   = w_idle;
   assign busy        = !w_idle;
   assign burst_valid = r_burst_valid;
   assign burst_addr  = r_burst_addr;
   assign burst_len   = r_burst_len;
   assign burst_eol   = r_burst_eol;
   assign burst_last  = r_burst_last;
   assign aborted     = r_aborted;

endmodule

// File: tb/tb_dmac_burst_splitter.sv
// Scoreboard bench for dmac_burst_splitter at 64-bit data, 128-byte bursts.
module tb_dmac_burst_splitter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [23:0] req_x_length;
   logic [15:0] req_y_length;
   logic [23:0] req_stride;
   logic        req_abort;
   logic        burst_valid;
   logic        burst_ready;
   logic [31:0] burst_addr;
   logic [7:0]  burst_len;
   logic        burst_eol;
   logic        burst_last;
   logic        busy;
   logic        aborted;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic        eol;
      logic        last;
   } exp_t;

   exp_t sb[$];

   dmac_burst_splitter #(
      .ADDR_WIDTH          (32),
      .LENGTH_WIDTH        (24),
      .Y_LENGTH_WIDTH      (16),
      .DMA_DATA_WIDTH      (64),
      .MAX_BYTES_PER_BURST (128),
      .DMA_2D_TRANSFER     (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_x_length (req_x_length),
      .req_y_length (req_y_length),
      .req_stride   (req_stride),
      .req_abort    (req_abort),
      .burst_valid  (burst_valid),
      .burst_ready  (burst_ready),
      .burst_addr   (burst_addr),
      .burst_len    (burst_len),
      .burst_eol    (burst_eol),
      .burst_last   (burst_last),
      .busy         (busy),
      .aborted      (aborted)
   );

   always #5 clk = ~clk;

   task automatic push_exp(input logic [31:0] a, input logic [7:0] l,
                           input logic e, input logic t);
      exp_t x;
      x.addr = a; x.len = l; x.eol = e; x.last = t;
      sb.push_back(x);
   endtask

   task automatic start_req(input logic [31:0] a, input logic [23:0] x,
                            input logic [15:0] y, input logic [23:0] s);
      @(negedge clk);
      req_valid = 1'b1; req_addr = a; req_x_length = x;
      req_y_length = y; req_stride = s;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_x_length = '0;
      req_y_length = '0; req_stride = '0; req_abort = 1'b0; burst_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({req_ready, burst_valid, busy, aborted} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_ctrl got rdy/vld/busy/abt=%b want 1000",
                  {req_ready, burst_valid, busy, aborted});
      end
      checks++;
      if ({burst_addr, burst_len, burst_eol, burst_last} !== 42'd0) begin
         errors++;
         $display("FAIL reset_data got %h/%0d/%b/%b want 0/0/0/0",
                  burst_addr, burst_len, burst_eol, burst_last);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({req_ready, burst_valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL reset_release got %b want 100", {req_ready, burst_valid, busy});
      end
   endtask

   // Caller pushes the expected bursts; they must come out back to back.
   task automatic test_split(input string name, input logic [31:0] a,
                             input logic [23:0] x, input logic [15:0] y,
                             input logic [23:0] s);
      exp_t e;
      int   n;
      int   cyc;
      n = sb.size();
      burst_ready = 1'b1;
      start_req(a, x, y, s);
      cyc = 0;
      while (sb.size() > 0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (burst_valid && burst_ready) begin
            e = sb.pop_front();
            checks++;
            if ({burst_addr, burst_len, burst_eol, burst_last} !== {e.addr, e.len, e.eol, e.last}) begin
               errors++;
               $display("FAIL %s_burst got %h/%0d/%b/%b want %h/%0d/%b/%b", name,
                        burst_addr, burst_len, burst_eol, burst_last,
                        e.addr, e.len, e.eol, e.last);
            end
         end
      end
      checks++;
      if (cyc !== n) begin
         errors++;
         $display("FAIL %s_cycles got %0d want %0d", name, cyc, n);
      end
      sb.delete();
      @(negedge clk);
      checks++;
      if ({req_ready, busy, burst_valid} !== 3'b100) begin
         errors++;
         $display("FAIL %s_idle got rdy/busy/vld=%b want 100", name,
                  {req_ready, busy, burst_valid});
      end
   endtask

   task automatic test_stall();
      exp_t e;
      int   cyc;
      push_exp(32'h1000, 8'd15, 1'b0, 1'b0);
      push_exp(32'h1080, 8'd15, 1'b1, 1'b1);
      burst_ready = 1'b0;
      start_req(32'h1000, 24'd255, 16'd0, 24'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({burst_valid, burst_addr, burst_len, burst_eol, burst_last, req_ready, busy} !==
             {1'b1, 32'h1000, 8'd15, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL stall_hold%0d got v%b %h/%0d/%b/%b rdy%b busy%b want v1 1000/15/0/0 rdy0 busy1",
                     i, burst_valid, burst_addr, burst_len, burst_eol, burst_last, req_ready, busy);
         end
      end
      burst_ready = 1'b1;
      cyc = 0;
      while (sb.size() > 0 && cyc < 20) begin
         if (burst_valid && burst_ready) begin
            e = sb.pop_front();
            checks++;
            if ({burst_addr, burst_len, burst_eol, burst_last} !== {e.addr, e.len, e.eol, e.last}) begin
               errors++;
               $display("FAIL stall_burst got %h/%0d/%b/%b want %h/%0d/%b/%b",
                        burst_addr, burst_len, burst_eol, burst_last,
                        e.addr, e.len, e.eol, e.last);
            end
         end
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL stall_drain got %0d pending want 0", sb.size());
      end
      sb.delete();
      @(negedge clk);
   endtask

   task automatic test_abort();
      exp_t e;
      int   pulses;
      int   extra;
      push_exp(32'h1000, 8'd15, 1'b0, 1'b0);
      burst_ready = 1'b0;
      start_req(32'h1000, 24'd255, 16'd0, 24'd0);
      @(negedge clk);
      req_abort = 1'b1;
      @(posedge clk);
      #1 req_abort = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({burst_valid, burst_addr, aborted} !== {1'b1, 32'h1000, 1'b0}) begin
         errors++;
         $display("FAIL abort_hold got v%b %h abt%b want v1 1000 abt0",
                  burst_valid, burst_addr, aborted);
      end
      burst_ready = 1'b1;
      pulses = 0;
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         if (burst_valid && burst_ready) begin
            if (sb.size() == 0) begin
               extra++;
            end else begin
               e = sb.pop_front();
               checks++;
               if ({burst_addr, burst_len, burst_eol, burst_last} !== {e.addr, e.len, e.eol, e.last}) begin
                  errors++;
                  $display("FAIL abort_burst got %h/%0d/%b/%b want %h/%0d/%b/%b",
                           burst_addr, burst_len, burst_eol, burst_last,
                           e.addr, e.len, e.eol, e.last);
               end
            end
         end
         if (aborted) pulses++;
         @(negedge clk);
      end
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("FAIL abort_pulse got %0d pulses want 1", pulses);
      end
      checks++;
      if (extra !== 0 || sb.size() !== 0) begin
         errors++;
         $display("FAIL abort_bursts got extra=%0d pending=%0d want 0/0", extra, sb.size());
      end
      checks++;
      if ({req_ready, busy, burst_valid} !== 3'b100) begin
         errors++;
         $display("FAIL abort_idle got %b want 100", {req_ready, busy, burst_valid});
      end
      sb.delete();
   endtask

   task automatic test_abort_last();
      exp_t e;
      int   pulses;
      push_exp(32'h1000, 8'd15, 1'b0, 1'b0);
      push_exp(32'h1080, 8'd15, 1'b1, 1'b1);
      burst_ready = 1'b1;
      start_req(32'h1000, 24'd255, 16'd0, 24'd0);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (aborted) pulses++;
         if (burst_valid && burst_ready && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({burst_addr, burst_len, burst_eol, burst_last} !== {e.addr, e.len, e.eol, e.last}) begin
               errors++;
               $display("FAIL abortlast_burst got %h/%0d/%b/%b want %h/%0d/%b/%b",
                        burst_addr, burst_len, burst_eol, burst_last,
                        e.addr, e.len, e.eol, e.last);
            end
         end
         req_abort = burst_valid && burst_last;
      end
      req_abort = 1'b0;
      checks++;
      if (pulses !== 0 || sb.size() !== 0) begin
         errors++;
         $display("FAIL abortlast_end got pulses=%0d pending=%0d want 0/0", pulses, sb.size());
      end
      sb.delete();
   endtask

   task automatic test_reset_mid();
      burst_ready = 1'b1;
      start_req(32'h2000, 24'd63, 16'd2, 24'h100);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({burst_valid, burst_addr} !== {1'b1, 32'h2100}) begin
         errors++;
         $display("FAIL rstmid_pre got v%b %h want v1 2100", burst_valid, burst_addr);
      end
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({burst_valid, req_ready, busy, aborted} !== 4'b0100) begin
         errors++;
         $display("FAIL rstmid_post got vld/rdy/busy/abt=%b want 0100",
                  {burst_valid, req_ready, busy, aborted});
      end
   endtask

   initial begin
      test_reset();

      push_exp(32'h1000, 8'd15, 1'b0, 1'b0);
      push_exp(32'h1080, 8'd15, 1'b1, 1'b1);
      test_split("t1", 32'h1000, 24'd255, 16'd0, 24'd0);

      push_exp(32'h1040, 8'd7,  1'b0, 1'b0);
      push_exp(32'h1080, 8'd15, 1'b1, 1'b1);
      test_split("t2", 32'h1040, 24'd191, 16'd0, 24'd0);

      push_exp(32'h2000, 8'd7, 1'b1, 1'b0);
      push_exp(32'h2100, 8'd7, 1'b1, 1'b0);
      push_exp(32'h2200, 8'd7, 1'b1, 1'b1);
      test_split("t3_2d", 32'h2000, 24'd63, 16'd2, 24'h100);

      push_exp(32'h1000, 8'd15, 1'b0, 1'b0);
      push_exp(32'h1080, 8'd15, 1'b1, 1'b1);
      test_split("misaligned", 32'h1005, 24'd250, 16'd0, 24'd0);

      push_exp(32'h3000, 8'd15, 1'b1, 1'b0);
      push_exp(32'h3000, 8'd15, 1'b1, 1'b1);
      test_split("stride0", 32'h3000, 24'd127, 16'd1, 24'd0);

      push_exp(32'hFFFF_FFC0, 8'd7, 1'b0, 1'b0);
      push_exp(32'h0000_0000, 8'd7, 1'b1, 1'b1);
      test_split("wrap", 32'hFFFF_FFC0, 24'd127, 16'd0, 24'd0);

      push_exp(32'h40F0, 8'd1, 1'b0, 1'b0);
      push_exp(32'h4100, 8'd1, 1'b1, 1'b0);
      push_exp(32'h4110, 8'd3, 1'b1, 1'b1);
      test_split("row_cross", 32'h40F0, 24'd31, 16'd1, 24'h20);

      test_stall();
      test_abort();
      test_abort_last();
      test_reset_mid();

      push_exp(32'h1000, 8'd15, 1'b0, 1'b0);
      push_exp(32'h1080, 8'd15, 1'b1, 1'b1);
      test_split("after_reset", 32'h1000, 24'd255, 16'd0, 24'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
